regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scheduler for the 32x32 register file (two read ports, one write port, x0 hardwired to zero). It accepts writeback requests from two independent producers (port 0: ALU writeback, port 1: load/store writeback). Each producer is buffered in a small FIFO, and the arbiter grants the single register-file write port round-robin. It also exports a pending-write scoreboard so the hazard logic can stall reads of registers with writes still in flight.

---
 rtl/regfile_wb_pkg.sv | 21 ++
 rtl/regfile_wb_arbiter_fifo.sv | 79 +++++++
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg
// Shared widths, the writeback request record and a small decode helper for
// the register-file write-port arbiter and its per-requester FIFOs.
package regfile_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  // One-hot decode of a register index, used to build the pending mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    reg_onehot    = '0;
    reg_onehot[a] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo
// Small circular FIFO holding writeback requests for one producer.
// Each slot carries its own valid bit so the scoreboard can see exactly which
// destination registers are still buffered.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset (flushes all slots)
//   i_push, i_push_req  enqueue a request (ignored while full)
//   i_pop               dequeue the head (ignored while empty)
//   o_full, o_empty     occupancy flags, from registered state
//   o_head              request at the read pointer
//   o_entry_valid       per-slot valid bits
//   o_entry_addr        per-slot destination register
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_push,
  input  wb_req_t                              i_push_req,
  input  logic                                 i_pop,
  output logic                                 o_full,
  output logic                                 o_empty,
  output wb_req_t                              o_head,
  output logic [DEPTH-1:0]                     o_entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     o_entry_addr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t            mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic               do_push;
  logic               do_pop;

  assign o_full  = &valid_q;
  assign o_empty = ~|valid_q;
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;
  assign o_head  = mem_q[rd_ptr_q];
  assign o_entry_valid = valid_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_entry_addr[i] = mem_q[i].addr;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. When not full,
  // the write slot differs from the read slot, so push and pop never collide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Payload storage needs no reset; slot validity is tracked separately.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= i_push_req;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Write-port arbiter for the 32x32 register file. Two producers (port 0: ALU
// writeback, port 1: load/store writeback) each feed a wb_fifo; a round-robin
// arbiter pops one head per cycle into a registered output stage that drives
// the register-file write port. A pending-write mask marks every register
// with a write still buffered or in the output stage.
//
// Handshake: a request on port p is taken at a rising edge when
// i_reqp_valid & o_reqp_ready. Ready depends only on registered FIFO state
// (not full); a full FIFO refuses even if it pops in the same cycle.
// Requests to x0 are taken but discarded.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req{0,1}_valid/_addr/_data request from each producer
//   o_req{0,1}_ready             producer may issue
//   o_wr_addr/_data/_wren        register-file write port
//   o_pending                    bit k set while a write to xk is in flight
//   o_idle                       nothing buffered and no write in the output stage
//   o_grant_cnt0/1, o_conflict_cnt  statistics, present only when
//                                REGFILE_WB_ARB_STATS_EN is defined
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [REG_ADDR_W-1:0] i_req0_addr,
  input  logic [REG_DATA_W-1:0] i_req0_data,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [REG_ADDR_W-1:0] i_req1_addr,
  input  logic [REG_DATA_W-1:0] i_req1_data,
  output logic [REG_ADDR_W-1:0] o_wr_addr,
  output logic [REG_DATA_W-1:0] o_wr_data,
  output logic                  o_wr_wren,
  output logic [NUM_REGS-1:0]   o_pending,
  output logic                  o_idle
`ifdef REGFILE_WB_ARB_STATS_EN
  ,
  output logic [31:0]           o_grant_cnt0,
  output logic [31:0]           o_grant_cnt1,
  output logic [31:0]           o_conflict_cnt
`endif
);

  logic                              full0, full1, empty0, empty1;
  logic                              push0, push1;
  wb_req_t                           head0, head1;
  logic [DEPTH-1:0]                  ev0, ev1;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]  ea0, ea1;

  logic    grant0, grant1, contested;
  logic    rr_q, rr_d;
  logic    wren_q, wren_d;
  wb_req_t wr_q, wr_d;

  assign o_req0_ready = ~full0;
  assign o_req1_ready = ~full1;
  // x0 writes are acknowledged but never stored.
  assign push0 = i_req0_valid & o_req0_ready & (i_req0_addr != '0);
  assign push1 = i_req1_valid & o_req1_ready & (i_req1_addr != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_push(push0), .i_push_req('{addr: i_req0_addr, data: i_req0_data}),
    .i_pop(grant0),
    .o_full(full0), .o_empty(empty0), .o_head(head0),
    .o_entry_valid(ev0), .o_entry_addr(ea0)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_push(push1), .i_push_req('{addr: i_req1_addr, data: i_req1_data}),
    .i_pop(grant1),
    .o_full(full1), .o_empty(empty1), .o_head(head1),
    .o_entry_valid(ev1), .o_entry_addr(ea1)
  );

  // rr_q names the port that wins the next contested cycle; it only moves
  // when both heads compete, so an uncontested grant does not cost a turn.
  always_comb begin
    contested = ~empty0 & ~empty1;
    grant0    = ~empty0 & (empty1 | ~rr_q);
    grant1    = ~empty1 & (empty0 | rr_q);
    rr_d      = contested ? ~rr_q : rr_q;
    wren_d    = grant0 | grant1;
    wr_d      = wr_q;
    if (grant0) begin
      wr_d = head0;
    end else if (grant1) begin
      wr_d = head1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q   <= 1'b0;
      wren_q <= 1'b0;
      wr_q   <= '0;
    end else begin
      rr_q   <= rr_d;
      wren_q <= wren_d;
      wr_q   <= wr_d;
    end
  end

  assign o_wr_addr = wr_q.addr;
  assign o_wr_data = wr_q.data;
  assign o_wr_wren = wren_q;
  assign o_idle    = empty0 & empty1 & ~wren_q;

  always_comb begin
    o_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ev0[i]) o_pending = o_pending | reg_onehot(ea0[i]);
      if (ev1[i]) o_pending = o_pending | reg_onehot(ea1[i]);
    end
    if (wren_q) o_pending = o_pending | reg_onehot(wr_q.addr);
    o_pending[0] = 1'b0;
  end

`ifdef REGFILE_WB_ARB_STATS_EN
  logic [31:0] gcnt0_q, gcnt1_q, ccnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      ccnt_q  <= '0;
    end else begin
      if (grant0)    gcnt0_q <= gcnt0_q + 32'd1;
      if (grant1)    gcnt1_q <= gcnt1_q + 32'd1;
      if (contested) ccnt_q  <= ccnt_q + 32'd1;
    end
  end

  assign o_grant_cnt0   = gcnt0_q;
  assign o_grant_cnt1   = gcnt1_q;
  assign o_conflict_cnt = ccnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter (DEPTH=2). Writes seen on the write
// port are logged at each commit edge and compared in order against an
// expected queue; a small register-file image is kept for read-back checks.
// Build with REGFILE_WB_ARB_STATS_EN defined to also check the counters.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  localparam int SB_W = REG_ADDR_W + REG_DATA_W;

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  logic                  i_req0_valid, i_req1_valid;
  logic                  o_req0_ready, o_req1_ready;
  logic [REG_ADDR_W-1:0] i_req0_addr, i_req1_addr;
  logic [REG_DATA_W-1:0] i_req0_data, i_req1_data;
  logic [REG_ADDR_W-1:0] o_wr_addr;
  logic [REG_DATA_W-1:0] o_wr_data;
  logic                  o_wr_wren;
  logic [NUM_REGS-1:0]   o_pending;
  logic                  o_idle;
`ifdef REGFILE_WB_ARB_STATS_EN
  logic [31:0]           o_grant_cnt0, o_grant_cnt1, o_conflict_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [SB_W-1:0]       exp_q[$];
  logic [SB_W-1:0]       got_q[$];
  logic [REG_DATA_W-1:0] rf [NUM_REGS];
  wb_req_t               q0[$];
  wb_req_t               q1[$];

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_addr(i_req0_addr), .i_req0_data(i_req0_data),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_addr(i_req1_addr), .i_req1_data(i_req1_data),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_wren(o_wr_wren),
    .o_pending(o_pending), .o_idle(o_idle)
`ifdef REGFILE_WB_ARB_STATS_EN
    ,
    .o_grant_cnt0(o_grant_cnt0), .o_grant_cnt1(o_grant_cnt1),
    .o_conflict_cnt(o_conflict_cnt)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Register-file commit model: the write port is taken at the rising edge.
  always @(posedge i_clk) begin
    if (o_wr_wren) begin
      got_q.push_back({o_wr_addr, o_wr_data});
      if (o_wr_addr != '0) rf[o_wr_addr] <= o_wr_data;
    end
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  // Presents the head of q0/q1 every cycle, retiring an item only when it
  // was accepted (valid & ready seen before the edge).
  task automatic drive_streams(input bit bp_check);
    int  c = 0;
    bit  acc0, acc1;
    while ((q0.size() > 0 || q1.size() > 0) && c < 100) begin
      c++;
      i_req0_valid = (q0.size() > 0);
      i_req1_valid = (q1.size() > 0);
      if (q0.size() > 0) begin
        i_req0_addr = q0[0].addr;
        i_req0_data = q0[0].data;
      end
      if (q1.size() > 0) begin
        i_req1_addr = q1[0].addr;
        i_req1_data = q1[0].data;
      end
      if (bp_check && c == 4) chk("bp_ready0_low", 64'(o_req0_ready), 64'd0);
      if (bp_check && c == 5) chk("bp_ready0_back", 64'(o_req0_ready), 64'd1);
      acc0 = i_req0_valid && o_req0_ready;
      acc1 = i_req1_valid && o_req1_ready;
      step();
      if (acc0) void'(q0.pop_front());
      if (acc1) void'(q1.pop_front());
    end
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    chk("stream_accept_budget", 64'(c < 100), 64'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!o_idle && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, 64'(n < 50), 64'd1);
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_sb(input string tag);
    int i = 0;
    chk({tag, "_write_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      chk($sformatf("%s_write%0d", tag, i), 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
      i++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  function automatic wb_req_t mk(input int a, input logic [31:0] d);
    wb_req_t r;
    r.addr = REG_ADDR_W'(a);
    r.data = d;
    return r;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    bit seen_wren;
    i_rst = 1'b1;
    i_req0_valid = 1'b0; i_req0_addr = '0; i_req0_data = '0;
    i_req1_valid = 1'b0; i_req1_addr = '0; i_req1_data = '0;
    step();
    step();

    // Reset state
    chk("rst_wren", 64'(o_wr_wren), 64'd0);
    chk("rst_addr", 64'(o_wr_addr), 64'd0);
    chk("rst_data", 64'(o_wr_data), 64'd0);
    chk("rst_pending", 64'(o_pending), 64'd0);
    chk("rst_idle", 64'(o_idle), 64'd1);
    chk("rst_ready0", 64'(o_req0_ready), 64'd1);
    chk("rst_ready1", 64'(o_req1_ready), 64'd1);
`ifdef REGFILE_WB_ARB_STATS_EN
    chk("rst_gcnt0", 64'(o_grant_cnt0), 64'd0);
    chk("rst_gcnt1", 64'(o_grant_cnt1), 64'd0);
    chk("rst_ccnt", 64'(o_conflict_cnt), 64'd0);
`endif
    i_rst = 1'b0;

    // Single port: x3 = 0x30, accepted at edge N
    do_reset();
    i_req0_valid = 1'b1; i_req0_addr = 5'd3; i_req0_data = 32'h30;
    step();                                   // edge N
    i_req0_valid = 1'b0;
    chk("single_pending_n", 64'(o_pending), 64'h8);
    chk("single_wren_n", 64'(o_wr_wren), 64'd0);
    chk("single_idle_n", 64'(o_idle), 64'd0);
    step();                                   // edge N+1
    chk("single_wren_n1", 64'(o_wr_wren), 64'd1);
    chk("single_addr_n1", 64'(o_wr_addr), 64'd3);
    chk("single_data_n1", 64'(o_wr_data), 64'h30);
    chk("single_pending_n1", 64'(o_pending), 64'h8);
    step();                                   // edge N+2, commit
    chk("single_wren_n2", 64'(o_wr_wren), 64'd0);
    chk("single_pending_n2", 64'(o_pending), 64'd0);
    chk("single_idle_n2", 64'(o_idle), 64'd1);
    chk("single_rf_x3", 64'(rf[3]), 64'h30);
    exp_q.push_back({5'd3, 32'h30});
    compare_sb("single");

    // Contention: port 0 x1..x4, port 1 x11..x14, alternating from port 0
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      q0.push_back(mk(k, 32'h0100_0000 | 32'(k)));
      q1.push_back(mk(k + 10, 32'h0B00_0000 | 32'(k)));
    end
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back({REG_ADDR_W'(k), 32'h0100_0000 | 32'(k)});
      exp_q.push_back({REG_ADDR_W'(k + 10), 32'h0B00_0000 | 32'(k)});
    end
    drive_streams(1'b0);
    drain("contend");
    compare_sb("contend");
    chk("contend_rf_x1", 64'(rf[1]), 64'h0100_0001);
    chk("contend_rf_x14", 64'(rf[14]), 64'h0B00_0004);
    chk("contend_pending_end", 64'(o_pending), 64'd0);

    // Backpressure: port 0 fills while port 1 competes; x8 waits for a pop
    do_reset();
    for (int k = 5; k <= 8; k++) q0.push_back(mk(k, 32'h5000_0000 | 32'(k)));
    for (int k = 15; k <= 17; k++) q1.push_back(mk(k, 32'h6000_0000 | 32'(k)));
    exp_q.push_back({5'd5,  32'h5000_0005});
    exp_q.push_back({5'd15, 32'h6000_000F});
    exp_q.push_back({5'd6,  32'h5000_0006});
    exp_q.push_back({5'd16, 32'h6000_0010});
    exp_q.push_back({5'd7,  32'h5000_0007});
    exp_q.push_back({5'd17, 32'h6000_0011});
    exp_q.push_back({5'd8,  32'h5000_0008});
    drive_streams(1'b1);
    drain("bp");
    compare_sb("bp");

    // x0 drop: accepted, never written, never pending
    do_reset();
    i_req1_valid = 1'b1; i_req1_addr = 5'd0; i_req1_data = 32'hAABB_CCDD;
    chk("x0_ready1", 64'(o_req1_ready), 64'd1);
    step();
    i_req1_valid = 1'b0;
    chk("x0_idle", 64'(o_idle), 64'd1);
    chk("x0_pending", 64'(o_pending), 64'd0);
    seen_wren = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (o_wr_wren || o_pending != '0) seen_wren = 1'b1;
      step();
    end
    chk("x0_no_activity", 64'(seen_wren), 64'd0);
    chk("x0_no_writes", 64'(got_q.size()), 64'd0);

    // Reset mid-stream with entries buffered and a write in the output stage
    do_reset();
    i_req0_valid = 1'b1; i_req0_addr = 5'd7; i_req0_data = 32'h7777_0000;
    i_req1_valid = 1'b1; i_req1_addr = 5'd9; i_req1_data = 32'h9999_0000;
    for (int k = 0; k < 4; k++) step();
    chk("mid_pending_before", 64'(o_pending), 64'h280);
    chk("mid_idle_before", 64'(o_idle), 64'd0);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    i_rst = 1'b1;
    step();
    chk("mid_rst_wren", 64'(o_wr_wren), 64'd0);
    chk("mid_rst_addr", 64'(o_wr_addr), 64'd0);
    chk("mid_rst_data", 64'(o_wr_data), 64'd0);
    chk("mid_rst_pending", 64'(o_pending), 64'd0);
    chk("mid_rst_idle", 64'(o_idle), 64'd1);
    chk("mid_rst_ready0", 64'(o_req0_ready), 64'd1);
    chk("mid_rst_ready1", 64'(o_req1_ready), 64'd1);
    i_rst = 1'b0;
    got_q.delete();
    for (int k = 0; k < 4; k++) step();
    chk("mid_no_writes_after", 64'(got_q.size()), 64'd0);
    chk("mid_idle_after", 64'(o_idle), 64'd1);

`ifdef REGFILE_WB_ARB_STATS_EN
    // Stats: 11 edges of continuous requests give 10 contested cycles
    do_reset();
    i_req0_valid = 1'b1; i_req0_addr = 5'd20; i_req0_data = 32'h2000_0000;
    i_req1_valid = 1'b1; i_req1_addr = 5'd21; i_req1_data = 32'h2100_0000;
    for (int k = 0; k < 11; k++) step();
    chk("stats_ccnt", 64'(o_conflict_cnt), 64'd10);
    chk("stats_gcnt0", 64'(o_grant_cnt0), 64'd5);
    chk("stats_gcnt1", 64'(o_grant_cnt1), 64'd5);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    drain("stats");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
